// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller driving an external 1-bit
// full-adder cell, one operand bit per clock, LSB first.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, a, b, cin  request and operands, captured on the accepted start edge
//   fa_x, fa_y, fa_z  registered operand/carry bits to the full-adder cell
//   fa_s, fa_c        sum and carry returned by the cell (combinational)
//   busy              high during the WIDTH bit-serial cycles
//   done              one-cycle pulse when sum/cout/ovf have been updated
//   sum, cout, ovf    registered result, unsigned carry-out, signed overflow
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_z,
  input  logic             fa_s,
  input  logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned PW = WIDTH - 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  // Operand bits still to be presented; bit 0 of each operand sits in fa_x/fa_y.
  logic [PW-1:0]    a_sh_q;
  logic [PW-1:0]    b_sh_q;
  // Sum bits already returned by the cell, shifted in at the MSB.
  logic [PW-1:0]    psum_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_x_q;
  logic             fa_y_q;
  // Running carry register; it is also the z input of the cell.
  logic             fa_z_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             last_bit_c;

  assign last_bit_c = (cnt_q == CW'(WIDTH - 1));

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      cnt_q   <= '0;
      fa_x_q  <= 1'b0;
      fa_y_q  <= 1'b0;
      fa_z_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            fa_x_q  <= a[0];
            fa_y_q  <= b[0];
            fa_z_q  <= cin;
            a_sh_q  <= a[WIDTH-1:1];
            b_sh_q  <= b[WIDTH-1:1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          psum_q <= PW'({fa_s, psum_q} >> 1);
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit_c) begin
            // fa_z_q here is the carry into the MSB, so overflow is carry-in
            // of the MSB xor its carry-out.
            sum_q   <= {fa_s, psum_q};
            cout_q  <= fa_c;
            ovf_q   <= fa_c ^ fa_z_q;
            fa_x_q  <= 1'b0;
            fa_y_q  <= 1'b0;
            fa_z_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            fa_x_q <= a_sh_q[0];
            fa_y_q <= b_sh_q[0];
            fa_z_q <= fa_c;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fa_x = fa_x_q;
  assign fa_y = fa_y_q;
  assign fa_z = fa_z_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of serial_adder_ctrl
// (WIDTH=8) with a behavioural full-adder cell on the fa_* ports.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       fa_x;
  logic       fa_y;
  logic       fa_z;
  logic       fa_s;
  logic       fa_c;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  // Result the DUT is expected to be holding between operations.
  logic [7:0] hs;
  logic       hc;
  logic       ho;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .fa_x (fa_x),
    .fa_y (fa_y),
    .fa_z (fa_z),
    .fa_s (fa_s),
    .fa_c (fa_c),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  assign fa_s = fa_x ^ fa_y ^ fa_z;
  assign fa_c = (fa_x & fa_y) | (fa_x & fa_z) | (fa_y & fa_z);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: start edge is cycle 0, busy cycles 1..8, done at cycle 9.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input bit repulse);
    a = oa; b = ob; cin = oc; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~oa; b = oa ^ ob ^ 8'h5A; cin = ~oc;
    for (int c = 1; c <= 8; c++) begin
      chk("busy_shift", busy, 1);
      chk("done_shift", done, 0);
      chk("sum_held", sum, hs);
      chk("cout_held", cout, hc);
      chk("ovf_held", ovf, ho);
      if (c == 1) begin
        chk("fa_x_bit0", fa_x, oa[0]);
        chk("fa_y_bit0", fa_y, ob[0]);
        chk("fa_z_cin", fa_z, oc);
      end
      if (repulse && c == 3) begin
        start = 1'b1; a = 8'h55; b = 8'h33; cin = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
    chk("fa_x_done", fa_x, 0);
    chk("fa_y_done", fa_y, 0);
    chk("fa_z_done", fa_z, 0);
    hs = es; hc = ec; ho = eo;
    if (repulse) begin
      start = 1'b1; a = 8'hC3; b = 8'h3C;
    end
    tick();
    start = 1'b0;
    chk("done_cleared", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_after", sum, hs);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] rsum;
    logic       rovf;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    hs = '0; hc = 1'b0; ho = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_fa", {29'd0, fa_x, fa_y, fa_z}, 0);
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
    run_op(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Start re-pulsed mid-operation and in DONE; next op must see sum held.
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    run_op(8'h23, 8'h45, 1'b1, 8'h69, 1'b0, 1'b0, 1'b0);

    // Reset at cycle 4 of an operation aborts it without a done pulse.
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_fa", {29'd0, fa_x, fa_y, fa_z}, 0);
    hs = '0; hc = 1'b0; ho = 1'b0;
    // Start on the first edge after reset release.
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      rsum = 9'(ra) + 9'(rb) + 9'(rc);
      rovf = (ra[7] == rb[7]) && (rsum[7] != ra[7]);
      run_op(ra, rb, rc, rsum[7:0], rsum[8], rovf, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
